// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard unit: forwarding select, load-use/MDU stall, branch flush.
// Optional stall counter under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int MDU_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_load,
    input  logic              id_mdu,
    input  logic              br_taken,
    output logic              pc_write,
    output logic              if_write,
    output logic              if_flush,
    output logic              id_ex_bubble,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    input  logic              perf_clr,
    output logic [15:0]       stall_cnt,
`endif
    output logic              mdu_busy
);

    localparam int CW = $clog2(MDU_CYC);

    // Index 0 holds the youngest in-flight instruction (EX), index FWD_DEPTH-1 the oldest.
    logic [FWD_DEPTH-1:0] sb_valid;
    logic [FWD_DEPTH-1:0] sb_wr;
    logic [FWD_DEPTH-1:0] sb_load;
    logic [REG_AW-1:0]    sb_rd [FWD_DEPTH];

    logic [CW-1:0] mdu_cnt;
    logic          lu_a;
    logic          lu_b;
    logic          load_use;
    logic          mdu_hold;
    logic          stall;
    logic          issue;

    assign mdu_busy = (mdu_cnt != '0);
    assign mdu_hold = mdu_busy & id_valid;
    assign load_use = lu_a | lu_b;
    assign stall    = load_use | mdu_hold;
    assign issue    = id_valid & ~stall;

    assign pc_write     = ~stall;
    assign if_write     = ~stall;
    assign id_ex_bubble = stall;
    assign if_flush     = br_taken & id_valid & ~stall;

    // Walk oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        lu_a  = 1'b0;
        lu_b  = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (sb_valid[k] && sb_wr[k] && (sb_rd[k] == id_rs) && (id_rs != '0) && id_rs_used) begin
                fwd_a = 3'(k + 1);
                lu_a  = sb_load[k] && (k < LOAD_LAT);
            end
            if (sb_valid[k] && sb_wr[k] && (sb_rd[k] == id_rt) && (id_rt != '0) && id_rt_used) begin
                fwd_b = 3'(k + 1);
                lu_b  = sb_load[k] && (k < LOAD_LAT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_valid <= '0;
            sb_wr    <= '0;
            sb_load  <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sb_rd[k] <= '0;
            end
        end else begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_wr[k]    <= sb_wr[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            sb_valid[0] <= issue;
            sb_wr[0]    <= id_wr;
            sb_load[0]  <= id_load;
            sb_rd[0]    <= id_rd;
        end
    end

    // Issue cycle counts as the first cycle of occupancy, so the counter starts at MDU_CYC-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdu_cnt <= '0;
        end else if (issue && id_mdu) begin
            mdu_cnt <= CW'(MDU_CYC - 1);
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - CW'(1);
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven check of pipe_hazard_ctrl plus reset and perf sequences.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used, id_wr, id_load, id_mdu, br_taken;
    logic       pc_write, if_write, if_flush, id_ex_bubble, mdu_busy;
    logic [2:0] fwd_a, fwd_b;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic        perf_clr;
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr(id_wr), .id_rd(id_rd), .id_load(id_load), .id_mdu(id_mdu), .br_taken(br_taken),
        .pc_write(pc_write), .if_write(if_write), .if_flush(if_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .perf_clr(perf_clr), .stall_cnt(stall_cnt),
`endif
        .mdu_busy(mdu_busy)
    );

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs, rt;
        logic       rsu, rtu, wr;
        logic [4:0] rd;
        logic       ld, mdu, br;
        logic       pw, fl, bub;
        logic [2:0] fa, fb;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm,
                       input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic wr, input logic [4:0] rd,
                       input logic ld, input logic mdu, input logic br,
                       input logic pw, input logic fl, input logic bub,
                       input logic [2:0] fa, input logic [2:0] fb, input logic busy);
        vec_t t;
        t.name = nm; t.v = v; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu;
        t.wr = wr; t.rd = rd; t.ld = ld; t.mdu = mdu; t.br = br;
        t.pw = pw; t.fl = fl; t.bub = bub; t.fa = fa; t.fb = fb; t.busy = busy;
        tbl.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rs_used = t.rsu; id_rt_used = t.rtu;
        id_wr = t.wr; id_rd = t.rd; id_load = t.ld; id_mdu = t.mdu; br_taken = t.br;
    endtask

    task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b required %b (pw,iw,fl,bub,fa,fb,busy)", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic pw, input logic fl, input logic bub,
                           input logic [2:0] fa, input logic [2:0] fb, input logic busy);
        chk(nm, {pc_write, if_write, if_flush, id_ex_bubble, fwd_a, fwd_b, mdu_busy},
                {pw, pw, fl, bub, fa, fb, busy});
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_wr = 0; id_rd = 0; id_load = 0; id_mdu = 0; br_taken = 0;
    endtask

    initial begin
        //   name           v  rs rt rsu rtu wr rd ld mdu br | pw fl bub fa fb busy
        add("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 0);
        add("add_r3",       1, 1, 2, 1, 1, 1, 3, 0, 0, 0,     1, 0, 0, 0, 0, 0);
        add("fwd_a_1",      1, 3, 0, 1, 0, 0, 0, 0, 0, 0,     1, 0, 0, 1, 0, 0);
        add("fwd_a_2",      1, 3, 0, 1, 0, 0, 0, 0, 0, 0,     1, 0, 0, 2, 0, 0);
        add("lw_r5_fwd_3",  1, 3, 0, 1, 0, 1, 5, 1, 0, 0,     1, 0, 0, 3, 0, 0);
        add("load_use_br",  1, 0, 5, 0, 1, 1, 6, 0, 0, 1,     0, 0, 1, 0, 1, 0);
        add("after_lu_br",  1, 0, 5, 0, 1, 1, 6, 0, 0, 1,     1, 1, 0, 0, 2, 0);
        add("wr_r0",        1, 5, 0, 1, 0, 1, 0, 0, 0, 0,     1, 0, 0, 3, 0, 0);
        add("rs_r0_rt_r6",  1, 0, 6, 1, 1, 0, 0, 0, 0, 0,     1, 0, 0, 0, 2, 0);
        add("lw_r7",        1, 0, 0, 0, 0, 1, 7, 1, 0, 0,     1, 0, 0, 0, 0, 0);
        add("add_r7",       1, 0, 0, 0, 0, 1, 7, 0, 0, 0,     1, 0, 0, 0, 0, 0);
        add("younger_nold", 1, 7, 0, 1, 0, 0, 0, 0, 0, 0,     1, 0, 0, 1, 0, 0);
        add("mdu_issue",    1, 0, 0, 0, 0, 1, 8, 0, 1, 0,     1, 0, 0, 0, 0, 0);
        add("mdu_stall1",   1, 9, 0, 1, 0, 1,10, 0, 0, 0,     0, 0, 1, 0, 0, 1);
        add("mdu_stall2",   1, 9, 0, 1, 0, 1,10, 0, 0, 0,     0, 0, 1, 0, 0, 1);
        add("mdu_stall3",   1, 9, 0, 1, 0, 1,10, 0, 0, 0,     0, 0, 1, 0, 0, 1);
        add("mdu_resume",   1, 9, 0, 1, 0, 1,10, 0, 0, 0,     1, 0, 0, 0, 0, 0);
        add("br_no_valid",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,     1, 0, 0, 0, 0, 0);
        add("mdu2_issue",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0,     1, 0, 0, 0, 0, 0);
        add("mdu_on_busy1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,     0, 0, 1, 0, 0, 1);
        add("mdu_on_busy2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,     0, 0, 1, 0, 0, 1);
        add("mdu_on_busy3", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,     0, 0, 1, 0, 0, 1);
        add("mdu3_issue",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0,     1, 0, 0, 0, 0, 0);
        add("busy_no_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1);

        idle();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        perf_clr = 0;
`endif
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_out("in_reset", 1, 0, 0, 0, 0, 0);
        rst = 1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk_out(tbl[i].name, tbl[i].pw, tbl[i].fl, tbl[i].bub, tbl[i].fa, tbl[i].fb, tbl[i].busy);
        end

        // MDU counter sits at 2 here; reset must drop mdu_busy without waiting for a clock.
        @(negedge clk);
        idle();
        #1;
        chk_out("pre_reset_busy", 1, 0, 0, 0, 0, 1);
        rst = 0;
        #1;
        chk_out("async_reset", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        id_valid = 1; id_rs = 10; id_rs_used = 1;
        #1;
        chk_out("post_reset", 1, 0, 0, 0, 0, 0);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("perf_reset", {stall_cnt[10:0]} | {5'd0, |stall_cnt[15:11], 5'd0}, 11'd0);
        @(negedge clk);
        idle(); id_valid = 1; id_mdu = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle(); id_valid = 1;
        end
        @(negedge clk);
        #1;
        chk("perf_count3", stall_cnt[10:0] | {5'd0, |stall_cnt[15:11], 5'd0}, 11'd3);
        perf_clr = 1;
        @(negedge clk);
        perf_clr = 0;
        #1;
        chk("perf_clr", stall_cnt[10:0] | {5'd0, |stall_cnt[15:11], 5'd0}, 11'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
